// File: rtl/fpga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_pkg
//  Description : Shared types and constants for the FPGA bring-up path
//                (result reporter FSM states, frame slot counts).
//  Revision    : 1.0 - initial release
// ============================================================================
package fpga_pkg;

  // Frame phases of the serial LED reporter
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Slot counts of the fixed frame sections
  localparam int START_SLOTS = 1;
  localparam int STOP_SLOTS  = 2;

endpackage
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : slot_timer
//  Description : Free-running 0..TICK_DIV-1 slot counter with synchronous
//                clear; slot_end is high on the wrap cycle while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic slot_end
);

  localparam int                CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  // Wrap is decoded from the registered count only, so slot_end has no
  // path from any input other than enable.
  assign w_wrap   = (r_cnt == C_LAST);
  assign slot_end = enable && w_wrap;

  // Slot counter: cleared on request, otherwise counts and wraps while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_result_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : led_result_reporter
//  Description : Accepts one {carry, y} result over valid/ready and plays it
//                out on a single LED as START(1) / DATA MSB-first / STOP(0,0)
//                frame, each slot lasting TICK_DIV clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_result_reporter
  import fpga_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DATA_W   = 8
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic              in_carry,
  output logic              led,
  output logic              busy
);

  localparam int SH_W = DATA_W + 1;

  // The bit counter is reused to count START and STOP slots, so size it for
  // the largest of the three terminal values.
  localparam int C_MAX_A   = (DATA_W > STOP_SLOTS - 1) ? DATA_W : STOP_SLOTS - 1;
  localparam int C_MAX_CNT = (C_MAX_A > START_SLOTS - 1) ? C_MAX_A : START_SLOTS - 1;
  localparam int C_BIT_W   = (C_MAX_CNT > 0) ? $clog2(C_MAX_CNT + 1) : 1;

  localparam logic [C_BIT_W-1:0] C_DATA_LAST  = C_BIT_W'(DATA_W);
  localparam logic [C_BIT_W-1:0] C_START_LAST = C_BIT_W'(START_SLOTS - 1);
  localparam logic [C_BIT_W-1:0] C_STOP_LAST  = C_BIT_W'(STOP_SLOTS - 1);

  state_t             r_state;
  logic [C_BIT_W-1:0] r_bit_cnt;
  logic [SH_W-1:0]    r_shreg;
  logic               r_led;

  logic w_idle;
  logic w_accept;
  logic w_slot_end;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && in_valid;
  assign in_ready = w_idle;
  assign busy     = ~w_idle;
  assign led      = r_led;

  slot_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_slot_timer (
    .clk      (CLK100MHZ),
    .rst      (RST),
    .clear    (w_accept),
    .enable   (~w_idle),
    .slot_end (w_slot_end)
  );

  // Frame sequencer: state, slot/bit counting, shift register and LED flop
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_led     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_led <= 1'b0;
          if (w_accept) begin
            r_shreg   <= {in_carry, in_y};
            r_bit_cnt <= '0;
            r_led     <= 1'b1;
            r_state   <= START;
          end
        end

        START: begin
          if (w_slot_end) begin
            if (r_bit_cnt == C_START_LAST) begin
              r_bit_cnt <= '0;
              r_led     <= r_shreg[SH_W-1];
              r_state   <= DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (w_slot_end) begin
            r_shreg <= r_shreg << 1;
            if (r_bit_cnt == C_DATA_LAST) begin
              r_bit_cnt <= '0;
              r_led     <= 1'b0;
              r_state   <= STOP;
            end else begin
              // Next bit is the one about to shift into the MSB position
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_led     <= r_shreg[SH_W-2];
            end
          end
        end

        STOP: begin
          r_led <= 1'b0;
          if (w_slot_end) begin
            if (r_bit_cnt == C_STOP_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_result_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_result_reporter
//  Description : Scoreboard bench for led_result_reporter (TICK_DIV=4,
//                DATA_W=8). A reference model queues the expected per-cycle
//                {led, in_ready}; a monitor pops and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_result_reporter;

  localparam int TICK   = 4;
  localparam int DW     = 8;
  localparam int FRAME  = (DW + 4) * TICK;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_y;
  logic          in_carry;
  logic          led;
  logic          busy;

  int n_total;
  int n_bad;

  // Expected per-cycle response: bit1 = led, bit0 = in_ready
  logic [1:0] exp_q[$];
  int         busy_left;

  led_result_reporter #(
    .TICK_DIV (TICK),
    .DATA_W   (DW)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_carry  (in_carry),
    .led       (led),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is simply a list of slot levels, each repeated
  // TICK times; the block is unavailable for the FRAME cycles following an
  // accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(2'b01);
      busy_left = 0;
    end else begin
      if (busy_left == 0) begin
        if (in_valid) begin
          logic [DW:0] word;
          logic [DW+3:0] slots;
          word  = {in_carry, in_y};
          slots = {1'b1, word, 2'b00};
          for (int s = DW + 3; s >= 0; s--) begin
            for (int k = 0; k < TICK; k++) exp_q.push_back({slots[s], 1'b0});
          end
          busy_left = FRAME;
        end else begin
          exp_q.push_back(2'b01);
        end
      end else begin
        busy_left = busy_left - 1;
        if (busy_left == 0) exp_q.push_back(2'b01);
      end
    end
  end

  // Monitor: compare DUT against the head of the expected queue mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      n_total = n_total + 1;
      if (led !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_bad = n_bad + 1;
        $display("FAIL reset_state t=%0t got led=%b rdy=%b busy=%b want led=0 rdy=1 busy=0",
                 $time, led, in_ready, busy);
      end
    end else begin
      logic [1:0] e;
      n_total = n_total + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL scoreboard_empty t=%0t got led=%b rdy=%b want a queued entry",
                 $time, led, in_ready);
      end else begin
        e = exp_q.pop_front();
        if (led !== e[1] || in_ready !== e[0]) begin
          n_bad = n_bad + 1;
          $display("FAIL led_rdy t=%0t got led=%b rdy=%b want led=%b rdy=%b",
                   $time, led, in_ready, e[1], e[0]);
        end
      end
      n_total = n_total + 1;
      if (busy !== ~in_ready) begin
        n_bad = n_bad + 1;
        $display("FAIL busy_vs_ready t=%0t got busy=%b rdy=%b want busy=~rdy",
                 $time, busy, in_ready);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] y, input logic c);
    in_valid = 1'b1;
    in_y     = y;
    in_carry = c;
    cycles(1);
    in_valid = 1'b0;
    in_y     = DW'($urandom);
    in_carry = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_y     = '0;
    in_carry = 1'b0;
    cycles(3);

    // Reset state held with no traffic
    rst = 1'b0;
    cycles(6);

    // Single frame, y=0x08
    pulse(8'h08, 1'b0);
    cycles(55);

    // All ones including carry
    pulse(8'hFF, 1'b1);
    cycles(55);

    // Request while busy is ignored
    pulse(8'h0F, 1'b0);
    cycles(9);
    pulse(8'hAA, 1'b1);
    cycles(60);

    // Back-to-back with valid held high
    in_valid = 1'b1;
    in_y     = 8'h08;
    in_carry = 1'b0;
    cycles(1);
    in_y     = 8'h10;
    cycles(60);
    in_valid = 1'b0;
    cycles(45);

    // Reset asserted during data bit 4, then a clean frame
    pulse(8'h55, 1'b1);
    cycles(21);
    do_reset(3);
    cycles(2);
    pulse(8'h03, 1'b0);
    cycles(55);

    // Randomised traffic: single pulses, held valid, random gaps
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int hold;
        hold     = $urandom_range(1, 110);
        in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
          in_y     = DW'($urandom);
          in_carry = 1'($urandom);
          cycles(1);
        end
        in_valid = 1'b0;
      end else begin
        pulse(DW'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 9) == 0) begin
        cycles($urandom_range(0, 40));
        do_reset($urandom_range(1, 3));
      end
      cycles($urandom_range(0, 60));
    end

    in_valid = 1'b0;
    cycles(FRAME + 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus never completes
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got no completion want completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
